alu_op_sequencer: RTL

//  Control-side driver for the MiniSRC ALU. It accepts a fetched 32-bit IR from the

---
 rtl/minisrc_pkg.sv | 58 +++++
 rtl/alu_op_classify.sv | 28 ++
 rtl/alu_op_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/minisrc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minisrc_pkg
//  Purpose  : Shared MiniSRC ALU opcodes, IR field positions, sequencer state
//             encoding and the ALU instruction class enum.
//  Revision : 1.0 - initial release
// ============================================================================
package minisrc_pkg;

  // ALU opcodes (ir[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // IR field slice positions for a 32-bit IR
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP1  = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_LO   = 3'd4,
    S_HI   = 3'd5,
    S_ILL  = 3'd6
  } state_t;

  // R: reg,reg  I: reg,imm  U: unary on B  M: mul/div into LO/HI  X: not ALU-class
  typedef enum logic [2:0] {
    CLS_R = 3'd0,
    CLS_I = 3'd1,
    CLS_U = 3'd2,
    CLS_M = 3'd3,
    CLS_X = 3'd4
  } alu_class_t;

endpackage : minisrc_pkg
`default_nettype wire

// File: rtl/alu_op_classify.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_classify
//  Purpose  : Combinational opcode -> ALU instruction class decoder; shared
//             with the fetch controller.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_classify
  import minisrc_pkg::*;
(
  input  logic [4:0]  opcode,
  output alu_class_t  op_class
);

  always_comb begin
    op_class = CLS_X;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class = CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI:         op_class = CLS_I;
      OP_NEG, OP_NOT:                   op_class = CLS_U;
      OP_MUL, OP_DIV:                   op_class = CLS_M;
      default:                          op_class = CLS_X;
    endcase
  end

endmodule : alu_op_classify
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Steps the MiniSRC bus datapath through operand, execute and
//             write-back phases for one latched ALU-class instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import minisrc_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            start,
  input  logic [IR_W-1:0] ir,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [OP_W-1:0] alu_op,
  output logic [3:0]      reg_sel,
  output logic            r_out,
  output logic            r_in,
  output logic            c_out,
  output logic            y_in,
  output logic            z_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            lo_in,
  output logic            hi_in
);

  state_t            r_state;
  state_t            w_next_state;
  logic [IR_W-1:0]   r_ir;
  alu_class_t        w_in_class;
  alu_class_t        w_cur_class;
  logic [OP_W-1:0]   w_op;
  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [3:0]        w_rc;
  logic              w_unused_ir;

  assign w_op = r_ir[IR_OP_MSB:IR_OP_LSB];
  assign w_ra = r_ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb = r_ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc = r_ir[IR_RC_MSB:IR_RC_LSB];
  // Constant bits feed the datapath directly through c_out, not this block.
  assign w_unused_ir = ^r_ir[IR_RC_LSB-1:0];

  // The incoming IR picks the first state; the latched IR drives the rest.
  alu_op_classify u_classify_in (
    .opcode   (ir[IR_OP_MSB:IR_OP_LSB]),
    .op_class (w_in_class)
  );

  alu_op_classify u_classify_cur (
    .opcode   (w_op),
    .op_class (w_cur_class)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && start) begin
        r_ir <= ir;
      end
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_IDLE;
        if (start) begin
          case (w_in_class)
            CLS_X:   w_next_state = S_ILL;
            CLS_U:   w_next_state = S_EX;
            default: w_next_state = S_OP1;
          endcase
        end
      end
      S_OP1:   w_next_state = S_EX;
      S_EX:    w_next_state = (w_cur_class == CLS_M) ? S_LO : S_WB;
      S_LO:    w_next_state = S_HI;
      S_WB,
      S_HI,
      S_ILL:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    alu_op    = '0;
    reg_sel   = '0;
    r_out     = 1'b0;
    r_in      = 1'b0;
    c_out     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    case (r_state)
      S_OP1: begin
        reg_sel = (w_cur_class == CLS_M) ? w_ra : w_rb;
        r_out   = 1'b1;
        y_in    = 1'b1;
      end
      S_EX: begin
        alu_op = w_op;
        z_in   = 1'b1;
        case (w_cur_class)
          CLS_R: begin
            reg_sel = w_rc;
            r_out   = 1'b1;
          end
          CLS_I: c_out = 1'b1;
          default: begin
            reg_sel = w_rb;
            r_out   = 1'b1;
          end
        endcase
      end
      S_WB: begin
        alu_op   = w_op;
        zlow_out = 1'b1;
        reg_sel  = w_ra;
        r_in     = 1'b1;
        done     = 1'b1;
      end
      S_LO: begin
        alu_op   = w_op;
        zlow_out = 1'b1;
        lo_in    = 1'b1;
      end
      S_HI: begin
        alu_op    = w_op;
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
      S_ILL: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : alu_op_sequencer
`default_nettype wire
